// File: rtl/periph_rx_arbiter.sv
// periph_rx_arbiter
// Host-side reader for the per-peripheral RX FIFOs. Packets are pulled one at
// a time from NUM_PERIPHS standard FIFOs (1-cycle read latency) and handed to
// the USB transmit path over a valid/ready interface. Peripherals are served
// round-robin. Each grant may read at most BURST_LEN packets.
//
// Optional feature: define PERIPH_RX_ARB_URGENT_EN to give priority to
// requesters whose FIFO reports almost-full. Such a requester is also allowed
// to cut short the burst of a non-urgent grant. When the macro is undefined,
// periph_rx_almost_full is ignored.
//
// Read pipeline per packet:
//   READ    : rd_en pulses for one cycle
//   CAPTURE : FIFO dout is valid and is registered into usb_data
//   PRESENT : usb_valid is held until usb_ready
// periph_rx_empty is only consulted again in PRESENT. By then the flag already
// reflects the read that was just issued, so a FIFO is never read once too often.

module periph_rx_arbiter #(
    parameter int NUM_PERIPHS  = 4,
    parameter int PACKET_WIDTH = 32,
    parameter int BURST_LEN    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PERIPHS*PACKET_WIDTH-1:0]  periph_rx_data,
    input  logic [NUM_PERIPHS-1:0]               periph_rx_empty,
    input  logic [NUM_PERIPHS-1:0]               periph_rx_almost_full,
    input  logic [NUM_PERIPHS-1:0]               periph_ready,
    output logic [NUM_PERIPHS-1:0]               periph_rx_read,
    output logic [PACKET_WIDTH-1:0]              usb_data,
    output logic                                 usb_valid,
    input  logic                                 usb_ready,
    output logic [$clog2(NUM_PERIPHS)-1:0]       grant,
    output logic                                 busy
);

    localparam int PTR_W = $clog2(NUM_PERIPHS);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic [PTR_W-1:0]        last_ptr;
    logic [CNT_W-1:0]        burst_cnt;

    logic [NUM_PERIPHS-1:0]  req;
    logic [NUM_PERIPHS-1:0]  search_mask;
    logic [NUM_PERIPHS-1:0]  grant_oh;
    logic [PACKET_WIDTH-1:0] rx_word [NUM_PERIPHS];

    logic                    hit;
    logic [PTR_W-1:0]        hit_idx;
    logic [PTR_W:0]          cand;

    logic                    transfer;
    logic                    burst_more;
    logic                    preempt;

    // A peripheral requests only when it has data and has finished its own reset.
    assign req = ~periph_rx_empty & periph_ready;

    // One-hot form of the current grant. It drives rd_en and masks the grant out of the urgent check.
    assign grant_oh = {{(NUM_PERIPHS-1){1'b0}}, 1'b1} << grant;

    // Split the flattened FIFO outputs into one word per peripheral.
    for (genvar g = 0; g < NUM_PERIPHS; g++) begin : g_unpack
        assign rx_word[g] = periph_rx_data[g*PACKET_WIDTH +: PACKET_WIDTH];
    end

`ifdef PERIPH_RX_ARB_URGENT_EN
    logic [NUM_PERIPHS-1:0] urgent;

    // Urgent requesters hide the other requesters from the search. An urgent
    // requester other than the grant ends a non-urgent burst early.
    assign urgent      = req & periph_rx_almost_full;
    assign search_mask = (|urgent) ? urgent : req;
    assign preempt     = ~urgent[grant] & (|(urgent & ~grant_oh));
`else
    logic unused_almost_full;

    // Plain round-robin. The almost-full flags play no part in this build.
    assign search_mask        = req;
    assign preempt            = 1'b0;
    assign unused_almost_full = ^periph_rx_almost_full;
`endif

    // Round-robin search. Start one past the last burst owner, wrap modulo NUM_PERIPHS, take the first hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_PERIPHS; k++) begin
            cand = {1'b0, last_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_PERIPHS)) begin
                cand = cand - (PTR_W+1)'(NUM_PERIPHS);
            end
            if (!hit && search_mask[cand[PTR_W-1:0]]) begin
                hit     = 1'b1;
                hit_idx = cand[PTR_W-1:0];
            end
        end
    end

    // A packet leaves in the cycle where PRESENT meets usb_ready. The burst goes
    // on only if it has room, the grant still requests, and nobody preempts it.
    assign transfer   = (state == PRESENT) && usb_ready;
    assign burst_more = ((int'(burst_cnt) + 1) < BURST_LEN) && req[grant] && !preempt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> READ -> CAPTURE -> PRESENT, then loop for the burst or return to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hit) begin
                    next_state = READ;
                end
            end
            READ: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                next_state = PRESENT;
            end
            PRESENT: begin
                if (transfer) begin
                    next_state = burst_more ? READ : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State-decoded outputs. rd_en can only go high in READ, so at most one bit is set.
    always_comb begin
        periph_rx_read = '0;
        busy           = (state != IDLE);
        if (state == READ) begin
            periph_rx_read = grant_oh;
        end
    end

    // Datapath: grant and burst bookkeeping, round-robin pointer, output holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            last_ptr  <= PTR_W'(NUM_PERIPHS - 1);
            burst_cnt <= '0;
            usb_data  <= '0;
            usb_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        grant     <= hit_idx;
                        burst_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    usb_data  <= rx_word[grant];
                    usb_valid <= 1'b1;
                end
                PRESENT: begin
                    if (transfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        usb_valid <= 1'b0;
                        if (!burst_more) begin
                            last_ptr <= grant;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// tb_periph_rx_arbiter
// Self-checking bench for periph_rx_arbiter. The bench models each peripheral
// as a standard 1-cycle-latency FIFO. Directed steps cover reset, latency,
// back-pressure, ready gating and mid-operation reset. Randomized rounds then
// compare the observed packet order against a packet-level round-robin model.
// With PERIPH_RX_ARB_URGENT_EN defined, an urgent-preemption step is added.

module tb_periph_rx_arbiter;

    localparam int NP    = 4;
    localparam int PW    = 32;
    localparam int BL    = 4;
    localparam int GW    = $clog2(NP);
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*PW-1:0]  rx_data_flat;
    logic [NP-1:0]     empty_r;
    logic [NP-1:0]     af_r;
    logic [NP-1:0]     ready_r;
    logic [NP-1:0]     periph_rx_read;
    logic [PW-1:0]     usb_data;
    logic              usb_valid;
    logic              usb_ready_r;
    logic [GW-1:0]     grant;
    logic              busy;

    logic [PW-1:0]     dout [NP];
    logic [PW-1:0]     mem  [NP][DEPTH];
    int                head [NP];
    int                tail [NP];
    int                rd_cnt [NP];

    int                n_assert;
    int                n_fail;
    int                model_last;
    bit                rand_ready;

    logic [NP-1:0]     s_read;
    logic              s_valid;
    logic [PW-1:0]     s_data;
    logic [GW-1:0]     s_grant;
    logic              s_busy;
    logic              prev_stall;
    logic [PW-1:0]     prev_data;
    logic [GW-1:0]     prev_grant;

    int                obs_p [$];
    logic [PW-1:0]     obs_d [$];
    int                exp_p [$];
    logic [PW-1:0]     exp_d [$];

    always #5 clk = ~clk;

    // Flatten the per-peripheral FIFO outputs onto the DUT bus.
    always_comb begin
        rx_data_flat = '0;
        for (int i = 0; i < NP; i++) begin
            rx_data_flat[i*PW +: PW] = dout[i];
        end
    end

    periph_rx_arbiter #(
        .NUM_PERIPHS  (NP),
        .PACKET_WIDTH (PW),
        .BURST_LEN    (BL)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .periph_rx_data        (rx_data_flat),
        .periph_rx_empty       (empty_r),
        .periph_rx_almost_full (af_r),
        .periph_ready          (ready_r),
        .periph_rx_read        (periph_rx_read),
        .usb_data              (usb_data),
        .usb_valid             (usb_valid),
        .usb_ready             (usb_ready_r),
        .grant                 (grant),
        .busy                  (busy)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic load(input int p, input logic [PW-1:0] d);
        mem[p][tail[p]] = d;
        tail[p]++;
        empty_r[p] = 1'b0;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NP; i++) begin
            head[i]    = 0;
            tail[i]    = 0;
            empty_r[i] = 1'b1;
        end
    endtask

    // One clock. Sample at the negedge, check the rd_en rules and stall
    // stability, log transfers, then pop the FIFOs just after the posedge.
    task automatic tick();
        logic [NP-1:0] req_now;
        logic          read_ok;
        @(negedge clk);
        s_read  = periph_rx_read;
        s_valid = usb_valid;
        s_data  = usb_data;
        s_grant = grant;
        s_busy  = busy;
        req_now = ~empty_r & ready_r;
        read_ok = ($countones(s_read) <= 1) && !((|s_read) && s_valid) && ((s_read & ~req_now) == '0);
        n_assert++;
        assert (read_ok)
        else begin
            n_fail++;
            $error("[TB] FAIL read_legal: periph_rx_read=%b usb_valid=%b, expected one-hot-or-zero to a requester (req=%b) with usb_valid=0",
                   s_read, s_valid, req_now);
        end
        if (prev_stall) begin
            check_output("stall_hold", {31'd0, s_valid, s_data}, {31'd0, 1'b1, prev_data});
            check_output("stall_grant", 64'(s_grant), 64'(prev_grant));
        end
        if (s_valid && usb_ready_r) begin
            obs_p.push_back(int'(s_grant));
            obs_d.push_back(s_data);
        end
        prev_stall = s_valid && !usb_ready_r;
        prev_data  = s_data;
        prev_grant = s_grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (s_read[i]) begin
                rd_cnt[i]++;
                if (head[i] != tail[i]) begin
                    dout[i] = mem[i][head[i]];
                    head[i]++;
                end
            end
            empty_r[i] = (head[i] == tail[i]);
        end
        if (rand_ready) begin
            usb_ready_r = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int k = 0;
        while (!s_valid && k < bound) begin
            tick();
            k++;
        end
        check_output(tag, 64'(s_valid), 64'd1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int k = 0;
        while (s_busy && k < bound) begin
            tick();
            k++;
        end
        check_output(tag, 64'(s_busy), 64'd0);
    endtask

    // Assert reset away from any clock edge. The outputs must clear at once, before the next edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        clear_fifos();
        prev_stall = 1'b0;
        #1;
        check_output("reset_read", 64'(periph_rx_read), 64'd0);
        check_output("reset_valid_busy", {62'd0, usb_valid, busy}, 64'd0);
        check_output("reset_data", 64'(usb_data), 64'd0);
        check_output("reset_grant", 64'(grant), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        s_valid    = 1'b0;
        s_busy     = 1'b0;
        model_last = NP - 1;
    endtask

    // Packet-level reference: round-robin from one past the last burst owner,
    // up to BL packets per grant, peripherals that are not ready never served.
    task automatic build_expected(input logic [NP-1:0] rdy);
        int  rem [NP];
        int  pos [NP];
        int  found;
        int  p;
        int  n;
        bit  more;
        exp_p.delete();
        exp_d.delete();
        for (int i = 0; i < NP; i++) begin
            rem[i] = rdy[i] ? (tail[i] - head[i]) : 0;
            pos[i] = head[i];
        end
        more = 1'b1;
        while (more) begin
            found = -1;
            for (int off = 1; off <= NP; off++) begin
                p = (model_last + off) % NP;
                if (found < 0 && rem[p] > 0) begin
                    found = p;
                end
            end
            if (found < 0) begin
                more = 1'b0;
            end else begin
                n = 0;
                while (n < BL && rem[found] > 0) begin
                    exp_p.push_back(found);
                    exp_d.push_back(mem[found][pos[found]]);
                    pos[found]++;
                    rem[found]--;
                    n++;
                end
                model_last = found;
            end
        end
    endtask

    initial begin
        int            base;
        int            bad;
        int            k;
        int            got;
        int            undrained;
        logic [NP-1:0] rdy;

        n_assert    = 0;
        n_fail      = 0;
        rand_ready  = 1'b0;
        rst         = 1'b1;
        af_r        = '0;
        ready_r     = '1;
        usb_ready_r = 1'b1;
        prev_stall  = 1'b0;
        s_valid     = 1'b0;
        s_busy      = 1'b0;
        model_last  = NP - 1;
        for (int i = 0; i < NP; i++) begin
            dout[i]   = '0;
            rd_cnt[i] = 0;
        end
        clear_fifos();
        $display("[TB] start");

        // Reset, then stay quiet for 100 cycles with every FIFO empty.
        do_reset();
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (s_read != '0 || s_valid || s_busy) bad++;
        end
        check_output("idle_quiet_cycles", 64'(bad), 64'd0);

        // A single packet in peripheral 2: rd_en next cycle, usb_valid two cycles after rd_en.
        load(2, 32'h8000_0055);
        base = obs_p.size();
        tick();
        check_output("t2_idle_sees_req", {60'd0, s_read}, 64'd0);
        tick();
        check_output("t2_read_pulse", 64'(s_read), 64'b0100);
        tick();
        check_output("t2_capture", {59'd0, s_valid, s_read}, 64'd0);
        tick();
        check_output("t2_valid", 64'(s_valid), 64'd1);
        check_output("t2_data", 64'(s_data), 64'h8000_0055);
        check_output("t2_grant", 64'(s_grant), 64'd2);
        tick();
        check_output("t2_back_idle", {62'd0, s_valid, s_busy}, 64'd0);
        check_output("t2_logged", 64'(obs_p.size() - base), 64'd1);
        if (obs_p.size() > base) begin
            check_output("t2_log_data", 64'(obs_d[base]), 64'h8000_0055);
        end

        // Back-pressure: usb_ready stays low for 10 cycles while usb_valid is up.
        usb_ready_r = 1'b0;
        load(0, 32'hA5A5_0001);
        load(0, 32'hA5A5_0002);
        wait_valid(10, "t5_first_valid");
        check_output("t5_first_data", 64'(s_data), 64'hA5A5_0001);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!(s_valid && s_data == 32'hA5A5_0001 && s_read == '0)) bad++;
        end
        check_output("t5_stall_cycles_bad", 64'(bad), 64'd0);
        usb_ready_r = 1'b1;
        base = obs_p.size();
        tick();
        check_output("t5_transfer_count", 64'(obs_p.size() - base), 64'd1);
        tick();
        check_output("t5_burst_next_read", {59'd0, s_valid, s_read}, {59'd0, 1'b0, 4'b0001});
        wait_valid(10, "t5_second_valid");
        check_output("t5_second_data", 64'(s_data), 64'hA5A5_0002);
        tick();
        wait_idle(20, "t5_idle");

        // A non-empty peripheral whose ready flag is low must never be read.
        ready_r[0] = 1'b0;
        load(0, 32'hDEAD_0000);
        load(0, 32'hDEAD_0001);
        base = rd_cnt[0];
        for (int c = 0; c < 30; c++) begin
            tick();
        end
        check_output("t6_not_ready_reads", 64'(rd_cnt[0] - base), 64'd0);
        check_output("t6_not_ready_busy", 64'(s_busy), 64'd0);
        clear_fifos();
        ready_r = '1;

        // Reset while a packet is held in the output register.
        load(1, 32'h1111_0001);
        load(1, 32'h1111_0002);
        load(1, 32'h1111_0003);
        wait_valid(10, "midreset_valid");
        do_reset();

`ifdef PERIPH_RX_ARB_URGENT_EN
        // Peripheral 1 starts a long burst. Peripheral 3 then turns urgent and is served after the current packet.
        for (int j = 0; j < 8; j++) load(1, 32'h1000_0000 | 32'(j));
        load(3, 32'h3000_0000);
        load(3, 32'h3000_0001);
        k = 0;
        while (s_read == '0 && k < 10) begin
            tick();
            k++;
        end
        check_output("urg_first_grant_read", 64'(s_read), 64'b0010);
        af_r[3] = 1'b1;
        base = obs_p.size();
        k = 0;
        while (obs_p.size() < base + 2 && k < 60) begin
            tick();
            k++;
        end
        check_output("urg_transfers", 64'(obs_p.size() - base), 64'd2);
        if (obs_p.size() >= base + 2) begin
            check_output("urg_order0", 64'(obs_p[base]), 64'd1);
            check_output("urg_order1", 64'(obs_p[base+1]), 64'd3);
        end
        k = 0;
        while ((s_busy || !(&empty_r)) && k < 200) begin
            tick();
            k++;
        end
        check_output("urg_drained", 64'(empty_r), 64'hF);
        af_r = '0;
        do_reset();
`endif

        // Randomized rounds. Each round preloads the FIFOs and randomizes back-pressure, then checks the packet order.
        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            clear_fifos();
            for (int i = 0; i < NP; i++) begin
                rdy[i] = ($urandom_range(0, 4) != 0);
            end
            ready_r = rdy;
            for (int i = 0; i < NP; i++) begin
                int cnt;
                cnt = $urandom_range(0, 6);
                for (int j = 0; j < cnt; j++) begin
                    load(i, (32'(i) << 28) | ($urandom & 32'h0FFF_FFFF));
                end
            end
            build_expected(rdy);
            base = obs_p.size();
            k = 0;
            while ((obs_p.size() < base + exp_p.size() || s_busy) && k < 3000) begin
                tick();
                k++;
            end
            for (int c = 0; c < 4; c++) begin
                tick();
            end
            check_output($sformatf("rand%0d_timeout", r), 64'(k >= 3000), 64'd0);
            got = obs_p.size() - base;
            check_output($sformatf("rand%0d_count", r), 64'(got), 64'(exp_p.size()));
            for (int j = 0; j < exp_p.size() && j < got; j++) begin
                check_output($sformatf("rand%0d_grant%0d", r, j), 64'(obs_p[base+j]), 64'(exp_p[j]));
                check_output($sformatf("rand%0d_data%0d", r, j), 64'(obs_d[base+j]), 64'(exp_d[j]));
            end
            undrained = 0;
            for (int i = 0; i < NP; i++) begin
                if (rdy[i] && head[i] != tail[i]) undrained++;
            end
            check_output($sformatf("rand%0d_undrained", r), 64'(undrained), 64'd0);
            if (k >= 3000) break;
        end
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
